cfg_chain_loader: RTL and testbench

CFG_CHAIN_LOADER -- requirements
Module: cfg_chain_loader

---
 rtl/cfg_chain_loader_if.sv | 26 ++
 rtl/cfg_chain_loader.sv | 158 +++++++++++++++
 tb/tb_cfg_chain_loader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_chain_loader_if.sv
// Programming and configuration bus for cfg_chain_loader.
// The master drives the programming pins; the slave is the loader itself.
interface cfg_chain_loader_if #(
    parameter int CHAIN_LEN = 64,
    parameter int LANES     = 1
);
    logic                 prog_clk;
    logic                 prog_rst;
    logic                 prog_en;
    logic [LANES-1:0]     prog_data_in;
    logic [LANES-1:0]     prog_data_out;
    logic [CHAIN_LEN-1:0] cfg_bits;
    logic                 cfg_valid;
    logic                 busy;
    logic                 err;

    modport master (
        output prog_clk, prog_rst, prog_en, prog_data_in,
        input  prog_data_out, cfg_bits, cfg_valid, busy, err
    );

    modport slave (
        input  prog_clk, prog_rst, prog_en, prog_data_in,
        output prog_data_out, cfg_bits, cfg_valid, busy, err
    );
endinterface

// File: rtl/cfg_chain_loader.sv
// Configuration chain loader: shifts a shadow chain from an asynchronous strobe
// and commits it atomically to cfg_bits. Optional CRC-8 check via CFG_CHAIN_CRC_EN.
module cfg_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int LANES     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    cfg_chain_loader_if.slave  bus
);
`ifdef CFG_CHAIN_CRC_EN
    localparam int CRC_W     = 8;
    localparam int PAY_BEATS = CHAIN_LEN / LANES;
`else
    localparam int CRC_W     = 0;
`endif
    localparam int SH_W  = CHAIN_LEN + CRC_W;
    localparam int BEATS = SH_W / LANES;
    localparam int CNT_W = $clog2(BEATS + 1);

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
            $error("cfg_chain_loader: LANES must be 1, 2, 4 or 8");
        end
        if (CHAIN_LEN <= 0 || (CHAIN_LEN % LANES) != 0) begin : g_bad_len
            $error("cfg_chain_loader: CHAIN_LEN must be a positive multiple of LANES");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [1:0]         strobe_sync;
    logic               strobe_prev;
    logic [1:0]         en_sync;
    logic [LANES-1:0]   data_s1;
    logic [LANES-1:0]   data_s2;
    logic [SH_W-1:0]    shadow;
    logic [SH_W-1:0]    shadow_next;
    logic [CNT_W-1:0]   beat_cnt;
    logic [CHAIN_LEN-1:0] cfg_reg;
    logic               cfg_valid_reg;
    logic               err_reg;
    logic               beat;
    logic               load_end;
    logic               crc_ok;

    // strobe_prev is the third stage that turns the synchronised strobe into an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_sync <= '0;
            strobe_prev <= 1'b0;
            en_sync     <= '0;
            data_s1     <= '0;
            data_s2     <= '0;
        end else begin
            strobe_sync <= {strobe_sync[0], bus.prog_clk};
            strobe_prev <= strobe_sync[1];
            en_sync     <= {en_sync[0], bus.prog_en};
            data_s1     <= bus.prog_data_in;
            data_s2     <= data_s1;
        end
    end

    assign beat        = strobe_sync[1] & ~strobe_prev & en_sync[1];
    assign shadow_next = (shadow << LANES) | SH_W'(data_s2);
    assign load_end    = beat && (state != DONE) && (beat_cnt == CNT_W'(BEATS - 1));

`ifdef CFG_CHAIN_CRC_EN
    logic [7:0] crc;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [LANES-1:0] d);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = LANES - 1; i >= 0; i--) begin
            fb = r[7] ^ d[i];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return r;
    endfunction

    // CRC runs over payload beats only; the trailing beats carry the reference
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (bus.prog_rst) begin
            crc <= '0;
        end else if (beat && state != DONE && beat_cnt < CNT_W'(PAY_BEATS)) begin
            crc <= crc8_step(crc, data_s2);
        end
    end

    assign crc_ok = (crc == shadow_next[7:0]);
`else
    assign crc_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.prog_rst) begin
            state_next = IDLE;
        end else if (beat) begin
            unique case (state)
                IDLE:    state_next = load_end ? DONE : SHIFT;
                SHIFT:   state_next = load_end ? DONE : SHIFT;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    // cfg_bits only moves on a complete, checked load so the fabric never sees partial data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow        <= '0;
            beat_cnt      <= '0;
            cfg_reg       <= '0;
            cfg_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else if (bus.prog_rst) begin
            shadow        <= '0;
            beat_cnt      <= '0;
            cfg_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else if (beat) begin
            shadow <= shadow_next;
            if (state == DONE) begin
                err_reg <= 1'b1;
            end else begin
                beat_cnt <= beat_cnt + CNT_W'(1);
                if (load_end) begin
                    if (crc_ok) begin
                        cfg_reg       <= shadow_next[SH_W-1 -: CHAIN_LEN];
                        cfg_valid_reg <= 1'b1;
                    end else begin
                        err_reg <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.prog_data_out = shadow[SH_W-1 -: LANES];
    assign bus.cfg_bits      = cfg_reg;
    assign bus.cfg_valid     = cfg_valid_reg;
    assign bus.busy          = (state == SHIFT);
    assign bus.err           = err_reg;
endmodule

// File: tb/tb_cfg_chain_loader.sv
// Scoreboard bench for cfg_chain_loader with a 1-lane and a 4-lane 16-bit chain;
// the CRC scenarios are built only when CFG_CHAIN_CRC_EN is defined.
module tb_cfg_chain_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [15:0] exp_q[$];

    cfg_chain_loader_if #(.CHAIN_LEN(16), .LANES(1)) bus1();
    cfg_chain_loader_if #(.CHAIN_LEN(16), .LANES(4)) bus4();

    cfg_chain_loader #(.CHAIN_LEN(16), .LANES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    cfg_chain_loader #(.CHAIN_LEN(16), .LANES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    always #5 clk = ~clk;

`ifdef CFG_CHAIN_CRC_EN
    function automatic logic [7:0] crc8_ref(input logic [15:0] v);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 15; i >= 0; i--) begin
            fb = c[7] ^ v[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction
`endif

    task automatic beat1(input logic d, input logic en);
        bus1.prog_data_in = d;
        bus1.prog_en      = en;
        repeat (2) @(posedge clk);
        #1 bus1.prog_clk = 1'b1;
        repeat (4) @(posedge clk);
        #1 bus1.prog_clk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic beat4(input logic [3:0] d);
        bus4.prog_data_in = d;
        bus4.prog_en      = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus4.prog_clk = 1'b1;
        repeat (4) @(posedge clk);
        #1 bus4.prog_clk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic shift1(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) beat1(v[i], 1'b1);
    endtask

    task automatic load1(input logic [15:0] v);
        shift1(v, 16);
`ifdef CFG_CHAIN_CRC_EN
        shift1({8'h00, crc8_ref(v)}, 8);
`endif
    endtask

    task automatic prst1();
        @(posedge clk);
        #1 bus1.prog_rst = 1'b1;
        @(posedge clk);
        #1 bus1.prog_rst = 1'b0;
    endtask

    task automatic wait_valid1(output bit seen);
        int n = 0;
        while (bus1.cfg_valid !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        seen = (bus1.cfg_valid === 1'b1);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus1.cfg_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus1.cfg_valid); end
        total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus1.busy); end
        total++; if (bus1.err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus1.err); end
        total++; if (bus1.cfg_bits !== 16'h0000) begin bad++; $display("FAIL reset_cfg: got %h want 0000", bus1.cfg_bits); end
        total++; if (bus4.prog_data_out !== 4'h0) begin bad++; $display("FAIL reset_pdo: got %h want 0", bus4.prog_data_out); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        int n = 0;
        bus1.prog_data_in = 1'b1;
        bus1.prog_en      = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus1.prog_clk = 1'b1;
        while (bus1.busy !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++; if (n != 3) begin bad++; $display("FAIL beat_latency: got %0d cycles want 3", n); end
        repeat (2) @(posedge clk);
        #1 bus1.prog_clk = 1'b0;
        repeat (4) @(posedge clk);
        prst1();
    endtask

    task automatic test_load_lanes1();
        bit seen;
        logic [15:0] exp;
        exp_q.push_back(16'hA5C3);
        load1(16'hA5C3);
        wait_valid1(seen);
        total++; if (!seen) begin bad++; $display("FAIL l1_valid: got %b want 1", bus1.cfg_valid); end
        exp = exp_q.pop_front();
        total++; if (bus1.cfg_bits !== exp) begin bad++; $display("FAIL l1_cfg: got %h want %h", bus1.cfg_bits, exp); end
        total++; if (bus1.err !== 1'b0) begin bad++; $display("FAIL l1_err: got %b want 0", bus1.err); end
    endtask

    task automatic test_overshift();
        beat1(1'b1, 1'b1);
        total++; if (bus1.err !== 1'b1) begin bad++; $display("FAIL over_err: got %b want 1", bus1.err); end
        total++; if (bus1.cfg_bits !== 16'hA5C3) begin bad++; $display("FAIL over_cfg: got %h want a5c3", bus1.cfg_bits); end
    endtask

    task automatic test_lanes4();
        int n = 0;
        logic [15:0] exp;
        exp_q.push_back(16'h1234);
        beat4(4'h1); beat4(4'h2); beat4(4'h3); beat4(4'h4);
`ifdef CFG_CHAIN_CRC_EN
        begin
            logic [7:0] c;
            c = crc8_ref(16'h1234);
            beat4(c[7:4]);
            beat4(c[3:0]);
        end
`endif
        while (bus4.cfg_valid !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++; if (bus4.cfg_valid !== 1'b1) begin bad++; $display("FAIL l4_valid: got %b want 1", bus4.cfg_valid); end
        exp = exp_q.pop_front();
        total++; if (bus4.cfg_bits !== exp) begin bad++; $display("FAIL l4_cfg: got %h want %h", bus4.cfg_bits, exp); end
        total++; if (bus4.prog_data_out !== 4'h1) begin bad++; $display("FAIL l4_pdo: got %h want 1", bus4.prog_data_out); end
    endtask

    task automatic test_prog_rst_hold();
        bit seen;
        logic [15:0] exp;
        prst1();
        exp_q.push_back(16'hFFFF);
        load1(16'hFFFF);
        wait_valid1(seen);
        exp = exp_q.pop_front();
        total++; if (!seen || bus1.cfg_bits !== exp) begin bad++; $display("FAIL ff_cfg: got %h want %h", bus1.cfg_bits, exp); end
        prst1();
        shift1(16'hFFFF, 8);
        total++; if (bus1.cfg_valid !== 1'b0) begin bad++; $display("FAIL hold_valid: got %b want 0", bus1.cfg_valid); end
        total++; if (bus1.cfg_bits !== 16'hFFFF) begin bad++; $display("FAIL hold_cfg: got %h want ffff", bus1.cfg_bits); end
        total++; if (bus1.busy !== 1'b1) begin bad++; $display("FAIL hold_busy: got %b want 1", bus1.busy); end
        total++; if (bus1.err !== 1'b0) begin bad++; $display("FAIL hold_err: got %b want 0", bus1.err); end
        #2 rst_n = 1'b0;
        #2;
        total++; if (bus1.cfg_bits !== 16'h0000) begin bad++; $display("FAIL arst_cfg: got %h want 0000", bus1.cfg_bits); end
        total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL arst_busy: got %b want 0", bus1.busy); end
        total++; if (bus1.cfg_valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b want 0", bus1.cfg_valid); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_enable_gating();
        bit seen;
        logic [15:0] exp;
        exp_q.push_back(16'h3C96);
        shift1(16'h003C, 8);
        for (int i = 0; i < 5; i++) beat1(1'b1, 1'b0);
        total++; if (bus1.busy !== 1'b1) begin bad++; $display("FAIL gate_busy: got %b want 1", bus1.busy); end
        total++; if (bus1.cfg_valid !== 1'b0) begin bad++; $display("FAIL gate_valid: got %b want 0", bus1.cfg_valid); end
        shift1(16'h0096, 8);
`ifdef CFG_CHAIN_CRC_EN
        shift1({8'h00, crc8_ref(16'h3C96)}, 8);
`endif
        wait_valid1(seen);
        exp = exp_q.pop_front();
        total++; if (!seen || bus1.cfg_bits !== exp) begin bad++; $display("FAIL gate_cfg: got %h want %h", bus1.cfg_bits, exp); end
    endtask

    task automatic test_coincident_rst();
        bit seen;
        logic [15:0] exp;
        prst1();
        shift1(16'h000F, 4);
        bus1.prog_data_in = 1'b1;
        bus1.prog_en      = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus1.prog_clk = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus1.prog_rst = 1'b1;
        @(posedge clk);
        #1 bus1.prog_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus1.prog_clk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL coinc_busy: got %b want 0", bus1.busy); end
        exp_q.push_back(16'h5A0F);
        load1(16'h5A0F);
        wait_valid1(seen);
        exp = exp_q.pop_front();
        total++; if (!seen || bus1.cfg_bits !== exp) begin bad++; $display("FAIL coinc_cfg: got %h want %h", bus1.cfg_bits, exp); end
    endtask

`ifdef CFG_CHAIN_CRC_EN
    task automatic test_crc();
        bit seen;
        logic [15:0] exp;
        prst1();
        exp_q.push_back(16'h0001);
        shift1(16'h0001, 16);
        shift1(16'h0007, 8);
        wait_valid1(seen);
        exp = exp_q.pop_front();
        total++; if (!seen || bus1.cfg_bits !== exp) begin bad++; $display("FAIL crc_good_cfg: got %h want %h", bus1.cfg_bits, exp); end
        total++; if (bus1.err !== 1'b0) begin bad++; $display("FAIL crc_good_err: got %b want 0", bus1.err); end
        prst1();
        shift1(16'h0001, 16);
        shift1(16'h0000, 8);
        total++; if (bus1.err !== 1'b1) begin bad++; $display("FAIL crc_bad_err: got %b want 1", bus1.err); end
        total++; if (bus1.cfg_valid !== 1'b0) begin bad++; $display("FAIL crc_bad_valid: got %b want 0", bus1.cfg_valid); end
        total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL crc_bad_busy: got %b want 0", bus1.busy); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit (total=%0d bad=%0d)", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus1.prog_clk = 1'b0; bus1.prog_rst = 1'b0; bus1.prog_en = 1'b0; bus1.prog_data_in = '0;
        bus4.prog_clk = 1'b0; bus4.prog_rst = 1'b0; bus4.prog_en = 1'b0; bus4.prog_data_in = '0;
        test_reset();
        test_latency();
        test_load_lanes1();
        test_overshift();
        test_lanes4();
        test_prog_rst_hold();
        test_enable_gating();
        test_coincident_rst();
`ifdef CFG_CHAIN_CRC_EN
        test_crc();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
